// File: rtl/cat_scene_pkg.sv
// ============================================================================
// Module : cat_scene_pkg
// Brief  : Shared encodings for the cat scene sequencer (arm pose, mode, FSM).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cat_scene_pkg;

    typedef enum logic [1:0] {
        ARM_REST = 2'd0,
        ARM_UP   = 2'd1,
        ARM_DOWN = 2'd2
    } arm_state_t;

    typedef enum logic [1:0] {
        MODE_STILL     = 2'd0,
        MODE_WAVE      = 2'd1,
        MODE_WALK      = 2'd2,
        MODE_WAVE_WALK = 2'd3
    } scene_mode_t;

    function automatic logic mode_waves(input scene_mode_t m);
        return (m == MODE_WAVE) || (m == MODE_WAVE_WALK);
    endfunction

    function automatic logic mode_walks(input scene_mode_t m);
        return (m == MODE_WALK) || (m == MODE_WAVE_WALK);
    endfunction

    // Waving alternates UP/DOWN after leaving REST; any non-waving mode parks the arm.
    function automatic arm_state_t arm_next(input arm_state_t cur, input scene_mode_t m);
        if (!mode_waves(m)) begin
            return ARM_REST;
        end
        return (cur == ARM_UP) ? ARM_DOWN : ARM_UP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_step_div.sv
// ============================================================================
// Module : frame_step_div
// Brief  : Frame-tick rising-edge detector and programmable step divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_step_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic [2:0] speed,
    output logic       frame_evt,
    output logic       step
);

    logic       r_tick_d;
    logic       r_live;
    logic [2:0] r_div;
    logic       w_rise;

    // r_live masks the first cycle after reset so a tick already high at release is not an edge.
    assign w_rise    = frame_tick & ~r_tick_d & r_live;
    assign frame_evt = w_rise & ~pause;
    assign step      = frame_evt & (speed <= r_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d <= 1'b0;
            r_live   <= 1'b0;
            r_div    <= 3'd0;
        end else begin
            r_tick_d <= frame_tick;
            r_live   <= 1'b1;
            if (frame_evt) begin
                r_div <= step ? 3'd0 : r_div + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cat_scene_sequencer.sv
// ============================================================================
// Module : cat_scene_sequencer
// Brief  : Per-frame cat sprite animation: arm wave FSM, walk offset, blink.
//          Blink logic present only when CAT_SCENE_BLINK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cat_scene_sequencer
    import cat_scene_pkg::*;
#(
    parameter int X_MAX        = 127,
    parameter int BLINK_PERIOD = 60,
    parameter int BLINK_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [1:0] mode,
    input  logic [2:0] speed,
    input  logic       pause,
    output logic [1:0] arm_pose,
    output logic       eyes_open,
    output logic [7:0] x_off
);

    localparam logic [7:0] c_X_MAX    = 8'(X_MAX);
    localparam logic [7:0] c_X_MAX_M1 = 8'(X_MAX - 1);

    logic        w_frame_evt;
    logic        w_step;
    scene_mode_t w_mode;
    scene_mode_t r_mode;
    arm_state_t  r_arm;
    logic [7:0]  r_x;
    logic        r_dir_left;

    frame_step_div u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .pause      (pause),
        .speed      (speed),
        .frame_evt  (w_frame_evt),
        .step       (w_step)
    );

    // The live input governs the event being evaluated; r_mode keeps the last sampled value.
    assign w_mode = w_frame_evt ? scene_mode_t'(mode) : r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_STILL;
            r_arm      <= ARM_REST;
            r_x        <= 8'd0;
            r_dir_left <= 1'b0;
        end else if (w_frame_evt) begin
            r_mode <= w_mode;
            if (w_step) begin
                r_arm <= arm_next(r_arm, w_mode);
                if (mode_walks(w_mode)) begin
                    if (r_dir_left) begin
                        if (r_x == 8'd0) begin
                            r_dir_left <= 1'b0;
                            r_x        <= 8'd1;
                        end else begin
                            r_x <= r_x - 8'd1;
                        end
                    end else begin
                        if (r_x == c_X_MAX) begin
                            r_dir_left <= 1'b1;
                            r_x        <= c_X_MAX_M1;
                        end else begin
                            r_x <= r_x + 8'd1;
                        end
                    end
                end
            end
        end
    end

    assign arm_pose = r_arm;
    assign x_off    = r_x;

`ifdef CAT_SCENE_BLINK_EN
    localparam int                c_BW    = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [c_BW-1:0]   c_LAST  = c_BW'(BLINK_PERIOD - 1);
    localparam logic [c_BW-1:0]   c_CLOSE = c_BW'(BLINK_PERIOD - BLINK_LEN);

    logic [c_BW-1:0] r_blink;
    logic            r_eyes;

    // Eye state follows the counter phase seen at the event, before it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= '0;
            r_eyes  <= 1'b1;
        end else if (w_frame_evt) begin
            r_eyes  <= (r_blink < c_CLOSE);
            r_blink <= (r_blink == c_LAST) ? '0 : r_blink + 1'b1;
        end
    end

    assign eyes_open = r_eyes;
`else
    assign eyes_open = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cat_scene_sequencer.sv
// ============================================================================
// Module : tb_cat_scene_sequencer
// Brief  : Self-checking bench, two parameterisations driven in lockstep.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cat_scene_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] speed = 3'd0;
    logic       pause = 1'b0;

    logic [1:0] arm_a, arm_b;
    logic       eyes_a, eyes_b;
    logic [7:0] x_a, x_b;

    int checks = 0;
    int failures = 0;

    int c_xmax[2] = '{127, 3};
    int c_bp[2]   = '{60, 10};
    int c_bl[2]   = '{6, 2};

    // Reference state: divider count, arm pose, number of walk steps, unpaused events.
    int m_div[2];
    int m_arm[2];
    int m_walk[2];
    int m_evt[2];
    int e_x[2];
    int e_eyes[2];

    always #5 clk = ~clk;

    cat_scene_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mode(mode),
        .speed(speed), .pause(pause), .arm_pose(arm_a), .eyes_open(eyes_a), .x_off(x_a)
    );

    cat_scene_sequencer #(.X_MAX(3), .BLINK_PERIOD(10), .BLINK_LEN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mode(mode),
        .speed(speed), .pause(pause), .arm_pose(arm_b), .eyes_open(eyes_b), .x_off(x_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " arm_a"},  32'(arm_a),  32'(m_arm[0]));
        chk({tag, " x_a"},    32'(x_a),    32'(e_x[0]));
        chk({tag, " eyes_a"}, 32'(eyes_a), 32'(e_eyes[0]));
        chk({tag, " arm_b"},  32'(arm_b),  32'(m_arm[1]));
        chk({tag, " x_b"},    32'(x_b),    32'(e_x[1]));
        chk({tag, " eyes_b"}, 32'(eyes_b), 32'(e_eyes[1]));
    endtask

    // Walk position is a triangle wave over the number of walk steps taken.
    function automatic int tri_pos(input int n, input int xm);
        int m;
        m = n % (2 * xm);
        return (m <= xm) ? m : 2 * xm - m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_div[i] = 0; m_arm[i] = 0; m_walk[i] = 0; m_evt[i] = 0;
            e_x[i] = 0; e_eyes[i] = 1;
        end
    endtask

    task automatic model_event(input int md, input int sp);
        bit stp;
        for (int i = 0; i < 2; i++) begin
            stp = (sp == m_div[i]) || (sp < m_div[i]);
            m_div[i] = stp ? 0 : m_div[i] + 1;
            if (stp) begin
                if (md == 1 || md == 3) m_arm[i] = (m_arm[i] == 1) ? 2 : 1;
                else                    m_arm[i] = 0;
                if (md == 2 || md == 3) m_walk[i]++;
            end
            e_x[i] = tri_pos(m_walk[i], c_xmax[i]);
`ifdef CAT_SCENE_BLINK_EN
            e_eyes[i] = (((m_evt[i]) % c_bp[i]) < (c_bp[i] - c_bl[i])) ? 1 : 0;
`else
            e_eyes[i] = 1;
`endif
            m_evt[i]++;
        end
    endtask

    task automatic frame_event(input int hold, input logic [1:0] md, input logic [2:0] sp,
                               input logic ps, input string tag);
        @(negedge clk);
        mode = md; speed = sp; pause = ps; frame_tick = 1'b1;
        check_all({tag, " pre"});
        if (!ps) model_event(int'(md), int'(sp));
        @(posedge clk);
        #1;
        check_all({tag, " post"});
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        check_all({tag, " settle"});
    endtask

    initial begin
        // Reset with frame_tick already high at release: no event may follow.
        model_reset();
        frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all("reset_tick_high");
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) frame_event(2, 2'd1, 3'd0, 1'b0, "wave");
        chk("wave final arm", 32'(arm_a), 32'd2);

        for (int k = 0; k < 9; k++) frame_event(1, 2'd2, 3'd2, 1'b0, "walk_div");
        chk("walk_div x_a", 32'(x_a), 32'd3);

        for (int k = 0; k < 2; k++) frame_event(1, 2'd3, 3'd0, 1'b0, "wave_walk");
        chk("pre_async arm", 32'(arm_a), 32'd2);
        chk("pre_async x",   32'(x_a),   32'd5);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) frame_event(1, 2'd2, 3'd0, 1'b0, "bounce");
        chk("bounce x_b", 32'(x_b), 32'd2);

        for (int k = 0; k < 5; k++) frame_event(2, 2'd3, 3'd0, 1'b1, "pause");
        frame_event(1, 2'd1, 3'd0, 1'b0, "unpause");

        frame_event(100, 2'd3, 3'd0, 1'b0, "long_tick");
        frame_event(1, 2'd3, 3'd0, 1'b0, "after_long");

        // Speed decrease below the current divider must step immediately.
        for (int k = 0; k < 3; k++) frame_event(1, 2'd3, 3'd7, 1'b0, "slow");
        frame_event(1, 2'd3, 3'd1, 1'b0, "speed_drop");

        for (int k = 0; k < 70; k++) begin
            frame_event(int'($urandom_range(1, 4)), 2'($urandom_range(0, 3)),
                        3'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
